// File: rtl/rbus_arbnto1_rr_pkg.sv
// Shared rbus arbitration types and the round-robin selection function.
package rbus_arbnto1_rr_pkg;

    localparam int N_DEF    = 5;
    localparam int LENW_DEF = 4;
    localparam int TMO_DEF  = 15;
    localparam int N_MAX    = 16;
    localparam int IDW_MAX  = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    typedef struct packed {
        logic               any;
        logic [N_MAX-1:0]   onehot;
        logic [IDW_MAX-1:0] idx;
    } rr_pick_t;

    // First requester at or above ptr, wrapping n-1 -> 0; ptr must be < n.
    function automatic rr_pick_t rr_pick(input logic [N_MAX-1:0] req,
                                         input logic [IDW_MAX-1:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = 0; k < N_MAX; k++) begin
            if (k < n) begin
                c = int'(ptr) + k;
                if (c >= n) c = c - n;
                if (!r.any && req[c[IDW_MAX-1:0]]) begin
                    r.any                    = 1'b1;
                    r.idx                    = c[IDW_MAX-1:0];
                    r.onehot[c[IDW_MAX-1:0]] = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rbus_arbnto1_rr_if.sv
// Request/grant bundle between the input channels, the output mux and the arbiter.
interface rbus_arbnto1_rr_if #(
    parameter int N    = 5,
    parameter int LENW = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]           i_req;
    logic [N-1:0][LENW-1:0] i_len;
    logic                   i_beat;
    logic                   i_dst_rdy;
    logic [N-1:0]           o_gnt;
    logic [IDW-1:0]         o_gnt_id;
    logic                   o_gnt_vld;
    logic                   ff_err;

    // Requesting side: channels and mux feed requests and beats, observe the grant.
    modport master (
        output i_req, i_len, i_beat, i_dst_rdy,
        input  o_gnt, o_gnt_id, o_gnt_vld, ff_err
    );

    // Arbiter side.
    modport slave (
        input  i_req, i_len, i_beat, i_dst_rdy,
        output o_gnt, o_gnt_id, o_gnt_vld, ff_err
    );

endinterface

// File: rtl/rbus_rr_pick.sv
// Combinational round-robin priority selector: request vector + pointer -> one-hot and index.
module rbus_rr_pick
    import rbus_arbnto1_rr_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IDW = $clog2(N);

    rr_pick_t pick;

    // Widen to the package's fixed width, select, then narrow back.
    always_comb begin
        pick   = rr_pick(N_MAX'(req), IDW_MAX'(ptr), N);
        onehot = pick.onehot[N-1:0];
        idx    = pick.idx[IDW-1:0];
        any    = pick.any;
    end

endmodule

// File: rtl/rbus_arbnto1_rr.sv
// Packet-granular round-robin arbiter driving the select of one rbus N-to-1 mux.
module rbus_arbnto1_rr
    import rbus_arbnto1_rr_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int LENW = LENW_DEF,
    parameter int TMO  = TMO_DEF
) (
    input logic               clk,
    input logic               rst,
    rbus_arbnto1_rr_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int WDW = $clog2(TMO + 1);

    arb_state_e     state;
    logic [IDW-1:0] ptr;
    logic [LENW-1:0] cnt;
    logic [WDW-1:0] wd;

    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] pick_ptr;
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           last_beat;
    logic           issue;

    // Search pointer: stored ptr when idle; one past the current winner while granted,
    // which leaves the winner last in line so it only wins again as sole requester.
    always_comb begin
        next_ptr  = (bus.o_gnt_id == IDW'(N - 1)) ? '0 : bus.o_gnt_id + 1'b1;
        pick_ptr  = (state == GRANT) ? next_ptr : ptr;
        last_beat = (state == GRANT) && bus.i_beat && (cnt == '0);
        issue     = bus.i_dst_rdy && pick_any && ((state == IDLE) || last_beat);
    end

    rbus_rr_pick #(.N(N)) u_pick (
        .req    (bus.i_req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant FSM with beat counter, watchdog and registered grant outputs.
    // NOTE: state updates use <= so every register samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            wd            <= '0;
            bus.o_gnt     <= '0;
            bus.o_gnt_id  <= '0;
            bus.o_gnt_vld <= 1'b0;
            bus.ff_err    <= 1'b0;
        end else if (issue) begin
            if (state == GRANT) ptr <= next_ptr;
            state         <= GRANT;
            cnt           <= bus.i_len[pick_idx];
            wd            <= '0;
            bus.o_gnt     <= pick_onehot;
            bus.o_gnt_id  <= pick_idx;
            bus.o_gnt_vld <= 1'b1;
        end else if (state == GRANT) begin
            if (bus.i_beat) begin
                wd <= '0;
                if (cnt == '0) begin
                    ptr           <= next_ptr;
                    state         <= IDLE;
                    bus.o_gnt     <= '0;
                    bus.o_gnt_vld <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (wd == WDW'(TMO - 1)) begin
                bus.ff_err    <= 1'b1;
                ptr           <= next_ptr;
                state         <= IDLE;
                bus.o_gnt     <= '0;
                bus.o_gnt_vld <= 1'b0;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rbus_arbnto1_rr.sv
// Directed bench for rbus_arbnto1_rr with a packet-level reference model checked every cycle.
module tb_rbus_arbnto1_rr;

    localparam int N    = 5;
    localparam int LENW = 4;
    localparam int TMO  = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    rbus_arbnto1_rr_if #(.N(N), .LENW(LENW)) bus ();

    rbus_arbnto1_rr #(.N(N), .LENW(LENW), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks who owns the output and how many words are left.
    bit m_act;
    int m_ch, m_id, m_left, m_quiet, m_ptr;
    bit m_err;

    function automatic int first_from(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit act, err, done;
        int ch, id, left, quiet, ptr, w;
        if (rst) begin
            m_act   <= 1'b0;
            m_ch    <= 0;
            m_id    <= 0;
            m_left  <= 0;
            m_quiet <= 0;
            m_ptr   <= 0;
            m_err   <= 1'b0;
        end else begin
            act = m_act; err = m_err; ch = m_ch; id = m_id;
            left = m_left; quiet = m_quiet; ptr = m_ptr; done = 1'b0;
            if (act) begin
                if (bus.i_beat) begin
                    quiet = 0;
                    left  = left - 1;
                    if (left == 0) begin
                        act  = 1'b0;
                        ptr  = (ch + 1) % N;
                        done = 1'b1;
                    end
                end else begin
                    quiet = quiet + 1;
                    if (quiet == TMO) begin
                        act = 1'b0;
                        err = 1'b1;
                        ptr = (ch + 1) % N;
                    end
                end
            end
            if ((!m_act || done) && bus.i_dst_rdy) begin
                w = first_from(bus.i_req, ptr);
                if (w >= 0) begin
                    act   = 1'b1;
                    ch    = w;
                    id    = w;
                    left  = int'(bus.i_len[w]) + 1;
                    quiet = 0;
                end
            end
            m_act <= act; m_err <= err; m_ch <= ch; m_id <= id;
            m_left <= left; m_quiet <= quiet; m_ptr <= ptr;
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        exp_gnt = m_act ? N'(1 << m_ch) : '0;
        check("cyc_gnt", 32'(bus.o_gnt), 32'(exp_gnt));
        check("cyc_gnt_id", 32'(bus.o_gnt_id), 32'(m_id));
        check("cyc_gnt_vld", 32'(bus.o_gnt_vld), 32'(m_act));
        check("cyc_err", 32'(bus.ff_err), 32'(m_err));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        bus.i_req  = '0;
        bus.i_beat = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_gnt", 32'(bus.o_gnt), 32'h0);
        check("rst_vld", 32'(bus.o_gnt_vld), 32'h0);
        check("rst_id", 32'(bus.o_gnt_id), 32'h0);
        check("rst_err", 32'(bus.ff_err), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        bus.i_len = '0;
    endtask

    initial begin
        bus.i_req     = '0;
        bus.i_len     = '0;
        bus.i_beat    = 1'b0;
        bus.i_dst_rdy = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("init_gnt", 32'(bus.o_gnt), 32'h0);
        check("init_err", 32'(bus.ff_err), 32'h0);

        // Single request on channel 2, four words.
        bus.i_req     = 5'b00100;
        bus.i_len[2]  = 4'd3;
        bus.i_dst_rdy = 1'b1;
        tick(1);
        check("s1_gnt", 32'(bus.o_gnt), 32'h04);
        check("s1_id", 32'(bus.o_gnt_id), 32'd2);
        bus.i_req  = '0;
        bus.i_beat = 1'b1;
        tick(3);
        check("s1_hold", 32'(bus.o_gnt), 32'h04);
        tick(1);
        check("s1_drop", 32'(bus.o_gnt), 32'h00);
        check("s1_id_hold", 32'(bus.o_gnt_id), 32'd2);
        bus.i_beat = 1'b0;
        // Pointer now 3: channels 0 and 3 compete, 3 wins.
        bus.i_req = 5'b01001;
        tick(1);
        check("s1_ptr3", 32'(bus.o_gnt), 32'h08);
        bus.i_req  = '0;
        bus.i_beat = 1'b1;
        tick(1);
        bus.i_beat = 1'b0;
        check("s1_idle", 32'(bus.o_gnt), 32'h00);
        pulse_rst();

        // All requesting, single-word packets, continuous beats: zero-bubble rotation.
        bus.i_req  = 5'b11111;
        bus.i_beat = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("s2_rot", 32'(bus.o_gnt), 32'(1 << (k % N)));
        end
        bus.i_req = '0;
        tick(1);
        check("s2_end", 32'(bus.o_gnt), 32'h00);
        bus.i_beat = 1'b0;
        pulse_rst();

        // Downstream not ready blocks granting.
        bus.i_req     = 5'b00011;
        bus.i_dst_rdy = 1'b0;
        tick(10);
        check("s3_block", 32'(bus.o_gnt), 32'h00);
        bus.i_dst_rdy = 1'b1;
        tick(1);
        check("s3_gnt0", 32'(bus.o_gnt), 32'h01);
        bus.i_req  = '0;
        bus.i_beat = 1'b1;
        tick(1);
        bus.i_beat = 1'b0;

        // Watchdog: channel 1, len 2, one beat then silence.
        bus.i_req    = 5'b00010;
        bus.i_len[1] = 4'd2;
        tick(1);
        check("s4_gnt1", 32'(bus.o_gnt), 32'h02);
        bus.i_req  = '0;
        bus.i_beat = 1'b1;
        tick(1);
        bus.i_beat = 1'b0;
        tick(TMO - 1);
        check("s4_pre_gnt", 32'(bus.o_gnt), 32'h02);
        check("s4_pre_err", 32'(bus.ff_err), 32'h0);
        tick(1);
        check("s4_exp_gnt", 32'(bus.o_gnt), 32'h00);
        check("s4_exp_err", 32'(bus.ff_err), 32'h1);
        bus.i_req    = 5'b00001;
        bus.i_len[0] = 4'd0;
        tick(1);
        check("s4_after_gnt", 32'(bus.o_gnt), 32'h01);
        bus.i_req  = '0;
        bus.i_beat = 1'b1;
        tick(1);
        bus.i_beat = 1'b0;
        check("s4_sticky", 32'(bus.ff_err), 32'h1);
        pulse_rst();

        // Length captured at grant; request drop and length change ignored.
        bus.i_req    = 5'b00001;
        bus.i_len[0] = 4'd3;
        tick(1);
        check("s5_gnt", 32'(bus.o_gnt), 32'h01);
        bus.i_req    = '0;
        bus.i_len[0] = 4'd0;
        bus.i_beat   = 1'b1;
        tick(3);
        check("s5_hold", 32'(bus.o_gnt), 32'h01);
        tick(1);
        check("s5_drop", 32'(bus.o_gnt), 32'h00);
        bus.i_beat = 1'b0;

        // Reset during the second beat of a four-word packet.
        bus.i_req    = 5'b00100;
        bus.i_len[2] = 4'd3;
        tick(1);
        check("s6_gnt", 32'(bus.o_gnt), 32'h04);
        bus.i_req  = '0;
        bus.i_beat = 1'b1;
        tick(1);
        #2 rst = 1'b1;
        #1;
        check("s6_async_gnt", 32'(bus.o_gnt), 32'h00);
        check("s6_async_vld", 32'(bus.o_gnt_vld), 32'h0);
        check("s6_async_id", 32'(bus.o_gnt_id), 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        bus.i_beat = 1'b0;
        bus.i_req  = 5'b01001;
        tick(1);
        check("s6_ptr0", 32'(bus.o_gnt), 32'h01);
        check("s6_id0", 32'(bus.o_gnt_id), 32'd0);
        bus.i_req  = '0;
        bus.i_beat = 1'b1;
        tick(1);
        bus.i_beat = 1'b0;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rbus_arbnto1_rr.md
# rbus_arbNto1_rr

Packet-granular round-robin arbiter that sequences one rbus N-to-1 output multiplexer. It picks one of N requesting rbus input channels, holds a one-hot grant for exactly the announced packet length, then re-arbitrates with no bubble. It sits beside each output mux in the demux/mux crossbar and drives that mux's select. A watchdog releases a grant held by a stalled requester and raises a sticky error.

## Interface
- N, 5, number of requesting input channels (2..16)
- LENW, 4, width of the packet-length field; packet length = len+1 words (1..2^LENW)
- TMO, 15, watchdog limit: max idle cycles between beats of a granted packet (1..255)

- clk  input  1  system clock; the only clock
- rst  input  1  asynchronous, active-high reset
- i_req  input  N  per-channel packet-pending request; level, held until granted
- i_len  input  N x LENW  per-channel packet length minus one; valid while i_req is high
- i_beat  input  1  accepted word on the muxed output (o_stb of the mux), counts toward the granted packet
- i_dst_rdy  input  1  downstream can accept a complete packet; sampled only when a new grant is issued
- o_gnt  output  N  one-hot grant; all-zero when idle
- o_gnt_id  output  $clog2(N)  binary index of the granted channel; holds last value when idle
- o_gnt_vld  output  1  a grant is active (equals |o_gnt)
- ff_err  output  1  sticky watchdog-expiry flag, cleared only by rst

## Operation
- States: IDLE, GRANT.
- IDLE: if i_dst_rdy=1 and any i_req=1, choose the winner round-robin starting at pointer ptr, wrapping N-1 -> 0. Register o_gnt/o_gnt_id, load beat counter cnt <= i_len[winner], load watchdog wd <= 0, go to GRANT.
- GRANT: each i_beat=1 clears wd. If cnt=0, the beat is the last; otherwise cnt <= cnt-1. Each cycle with i_beat=0 increments wd.
- On the last beat: ptr <= winner+1 (mod N). If i_dst_rdy=1 and another request is pending (the current winner is eligible only when it is the sole requester), issue the next grant at the same clock edge (back-to-back, zero bubble); otherwise drop to IDLE with o_gnt=0.
- Watchdog: if wd reaches TMO with i_beat=0, set ff_err, set ptr <= winner+1, clear o_gnt, go to IDLE. No new grant is issued on the expiry edge.
- i_len is captured only at grant time. Later changes are ignored until the next grant.
- Deasserting i_req while granted does not revoke the grant. The packet completes by beat count or by the watchdog.
- i_beat while IDLE is ignored. It does not affect ptr or ff_err.

## Timing
- Reset values: o_gnt=0, o_gnt_id=0, o_gnt_vld=0, ff_err=0, ptr=0, state IDLE, cnt=0, wd=0.
- Request-to-grant latency: 1 clock. Grant is asserted on the edge after i_req and i_dst_rdy are sampled high in IDLE.
- Grant release: o_gnt falls, or switches to the next winner, on the edge that samples the last i_beat. The mux therefore must not see a beat from the old winner after that edge.
- Simultaneous requests: lowest index at or above ptr wins, then wrap.
- Single-word packet (len=0): the first beat is also the last. The grant lasts exactly one beat.
- Watchdog: expiry happens on the edge after TMO consecutive beatless cycles in GRANT. The first counted cycle is the one following the grant edge.
- Asynchronous rst in mid-packet forces all outputs to their reset values immediately. No partial-packet state survives.

## Structure
- The shared rbus package holds the arbiter state enum (IDLE, GRANT) and a function rr_pick(req, ptr), which returns a one-hot and an index.
- One sub-module, rbus_rr_pick: a purely combinational round-robin priority selector (N-bit request, pointer in, one-hot and index out). The output-select logic of rbus_muxNto1 reuses the same sub-module.
- The top level contains the FSM, beat counter (LENW bits), watchdog counter ($clog2(TMO+1) bits) and ptr.

## Test plan
- Reset, then i_req=5'b00100, i_len[2]=3, i_dst_rdy=1 -> o_gnt=00100 and o_gnt_id=2 one clock later. The grant drops on the edge of the 4th beat. ptr=3.
- All five requests held, every i_len=0, continuous beats -> grants cycle 0,1,2,3,4,0 with one grant per clock and no idle cycle.
- i_req=00011 with i_dst_rdy=0 for 10 cycles -> o_gnt stays 0. i_dst_rdy rises -> channel 0 is granted next clock.
- Channel 1 granted with len=2, one beat, then no beats for TMO=15 cycles -> o_gnt=0 and ff_err=1 on the following edge. ff_err stays 1 through later traffic until rst.
- Channel 0 granted, i_len[0] changed and i_req[0] dropped mid-packet -> the grant still spans the originally captured length.
- rst pulsed during the 2nd beat of a 4-word packet -> all outputs are 0 immediately. After release, the first grant again starts the search at channel 0.
